// File: rtl/imem_program_loader.sv
`timescale 1ns/1ps
// Streams a counted, checksummed byte image into the split low/high instruction-memory files,
// holding the CPU for the duration of the load.
module imem_program_loader #(
  parameter int unsigned MAX_WORDS = 32
) (
  input  logic                          CLOCK,
  input  logic                          RESET_N,
  input  logic                          LOAD_START,
  input  logic [7:0]                    BYTE_IN,
  input  logic                          BYTE_VALID,
  output logic                          BYTE_READY,
  output logic [15:0]                   IMEM_DATA,
  output logic [$clog2(MAX_WORDS)-2:0]  WRITE_SELECT,
  output logic                          WRITE_ENABLE_LOW,
  output logic                          WRITE_ENABLE_HIGH,
  output logic                          CPU_HOLD,
  output logic                          LOAD_DONE,
  output logic                          LOAD_ERROR,
  output logic [$clog2(MAX_WORDS):0]    WORDS_WRITTEN
);

  localparam int unsigned AW = $clog2(MAX_WORDS);
  localparam int unsigned CW = AW + 1;
  localparam logic [7:0] MaxCount = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle, StCount, StHi, StLo, StWrite, StChk, StDone, StErr
  } state_e;

  state_e        state_q;
  logic [CW-1:0] addr_q;
  logic [CW-1:0] num_words_q;
  logic [7:0]    sum_q;
  logic [7:0]    data_hi_q;
  logic          xfer;
  logic [CW-1:0] addr_inc;

  assign xfer     = BYTE_VALID && BYTE_READY;
  assign addr_inc = addr_q + CW'(1);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q           <= StIdle;
      addr_q            <= '0;
      num_words_q       <= '0;
      sum_q             <= '0;
      data_hi_q         <= '0;
      BYTE_READY        <= 1'b0;
      IMEM_DATA         <= '0;
      WRITE_SELECT      <= '0;
      WRITE_ENABLE_LOW  <= 1'b0;
      WRITE_ENABLE_HIGH <= 1'b0;
      CPU_HOLD          <= 1'b0;
      LOAD_DONE         <= 1'b0;
      LOAD_ERROR        <= 1'b0;
      WORDS_WRITTEN     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (LOAD_START) begin
            LOAD_DONE     <= 1'b0;
            LOAD_ERROR    <= 1'b0;
            WORDS_WRITTEN <= '0;
            addr_q        <= '0;
            sum_q         <= '0;
            CPU_HOLD      <= 1'b1;
            BYTE_READY    <= 1'b1;
            state_q       <= StCount;
          end
        end
        StCount: begin
          if (xfer) begin
            if (BYTE_IN > MaxCount) begin
              BYTE_READY <= 1'b0;
              state_q    <= StErr;
            end else begin
              // A zero count byte stands for a full image.
              num_words_q <= (BYTE_IN == 8'd0) ? CW'(MAX_WORDS) : CW'(BYTE_IN);
              sum_q       <= BYTE_IN;
              state_q     <= StHi;
            end
          end
        end
        StHi: begin
          if (xfer) begin
            data_hi_q <= BYTE_IN;
            sum_q     <= sum_q + BYTE_IN;
            state_q   <= StLo;
          end
        end
        StLo: begin
          if (xfer) begin
            IMEM_DATA         <= {data_hi_q, BYTE_IN};
            WRITE_SELECT      <= addr_q[AW-2:0];
            WRITE_ENABLE_LOW  <= ~addr_q[AW-1];
            WRITE_ENABLE_HIGH <= addr_q[AW-1];
            sum_q             <= sum_q + BYTE_IN;
            BYTE_READY        <= 1'b0;
            state_q           <= StWrite;
          end
        end
        StWrite: begin
          WRITE_ENABLE_LOW  <= 1'b0;
          WRITE_ENABLE_HIGH <= 1'b0;
          addr_q            <= addr_inc;
          WORDS_WRITTEN     <= WORDS_WRITTEN + CW'(1);
          BYTE_READY        <= 1'b1;
          state_q           <= (addr_inc == num_words_q) ? StChk : StHi;
        end
        StChk: begin
          if (xfer) begin
            BYTE_READY <= 1'b0;
            state_q    <= (BYTE_IN == sum_q) ? StDone : StErr;
          end
        end
        StDone: begin
          LOAD_DONE <= 1'b1;
          CPU_HOLD  <= 1'b0;
          state_q   <= StIdle;
        end
        StErr: begin
          LOAD_ERROR <= 1'b1;
          CPU_HOLD   <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
